// File: rtl/sme_pkg.sv
// Shared types and width helpers for the string-match engine (sme_multi_match).
package sme_pkg;

    localparam int         BYTE_DEF  = 8;
    localparam logic [7:0] WILD_CODE = 8'h2E;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_STR,
        LOAD_PAT,
        SCAN,
        EMIT,
        FINAL
    } sme_state_e;

    // Index width for a buffer of 'depth' entries (never below one bit).
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a length counter that must be able to hold 'depth' itself.
    function automatic int len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sme_multi_match_if.sv
// Load/result port bundle of sme_multi_match.
interface sme_multi_match_if #(
    parameter int BYTE       = sme_pkg::BYTE_DEF,
    parameter int MAX_STRING = 32
) ();
    localparam int IW = sme_pkg::idx_w(MAX_STRING);
    localparam int CW = sme_pkg::len_w(MAX_STRING);

    logic [BYTE-1:0] chardata;
    logic            isstring;
    logic            ispattern;
    // A result beat transfers on a rising edge where valid && ready; while valid=1
    // and ready=0 the producer keeps valid, match, last and match_index unchanged.
    logic            ready;
    logic            valid;
    logic            match;
    logic [IW-1:0]   match_index;
    logic            last;
    logic            busy;
    logic [CW-1:0]   match_count;

    modport master (
        output chardata, isstring, ispattern, ready,
        input  valid, match, match_index, last, busy, match_count
    );

    modport slave (
        input  chardata, isstring, ispattern, ready,
        output valid, match, match_index, last, busy, match_count
    );

endinterface

// File: rtl/sme_cmp_pe.sv
// Compares the whole pattern against the string starting at one offset.
// With SME_WILDCARD_EN defined, a '.' pattern byte matches any string byte.
module sme_cmp_pe
    import sme_pkg::*;
#(
    parameter int BYTE        = BYTE_DEF,
    parameter int MAX_STRING  = 32,
    parameter int MAX_PATTERN = 8,
    parameter int OFF_W       = 8
) (
    input  logic [BYTE-1:0]                 str_mem [MAX_STRING],
    input  logic [BYTE-1:0]                 pat_mem [MAX_PATTERN],
    input  logic [len_w(MAX_PATTERN)-1:0]   pat_len,
    input  logic [OFF_W-1:0]                offset,
    output logic                            hit
);
    localparam int IW  = idx_w(MAX_STRING);
    localparam int PLW = len_w(MAX_PATTERN);

    logic [MAX_PATTERN-1:0] byte_ok;

    for (genvar j = 0; j < MAX_PATTERN; j++) begin : g_byte
        logic [OFF_W-1:0] pos;
        logic             in_range;
        logic [BYTE-1:0]  ch;
        logic             eq;

        assign pos      = offset + OFF_W'(j);
        assign in_range = (pos < OFF_W'(MAX_STRING));
        assign ch       = in_range ? str_mem[pos[IW-1:0]] : '0;
`ifdef SME_WILDCARD_EN
        assign eq = (pat_mem[j] == BYTE'(WILD_CODE)) || (ch == pat_mem[j]);
`else
        assign eq = (ch == pat_mem[j]);
`endif
        // Positions beyond the loaded pattern never veto the match.
        assign byte_ok[j] = (PLW'(j) >= pat_len) || (in_range && eq);
    end

    assign hit = (pat_len != '0) && (&byte_ok);

endmodule

// File: rtl/sme_multi_match.sv
// Multi-offset string matcher: loads a string and a pattern, then streams every
// match start index in ascending order followed by one terminator beat (SME_WILDCARD_EN optional).
module sme_multi_match
    import sme_pkg::*;
#(
    parameter int NUM_PE      = 4,
    parameter int MAX_STRING  = 32,
    parameter int MAX_PATTERN = 8,
    parameter int BYTE        = BYTE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    sme_multi_match_if.slave   bus,
    output sme_state_e         dbg_state
);
    localparam int IW  = idx_w(MAX_STRING);
    localparam int SLW = len_w(MAX_STRING);
    localparam int PIW = idx_w(MAX_PATTERN);
    localparam int PLW = len_w(MAX_PATTERN);
    localparam int LW  = idx_w(NUM_PE);
    localparam int OW  = $clog2(MAX_STRING + NUM_PE + 1) + 1;

    sme_state_e       state, state_nx;
    logic [SLW-1:0]   str_len, str_len_nx;
    logic [PLW-1:0]   pat_len, pat_len_nx;
    logic [OW-1:0]    base, base_nx;
    logic [NUM_PE-1:0] hits, hits_nx;
    logic [SLW-1:0]   cnt, cnt_nx;

    logic [BYTE-1:0]  str_buf [MAX_STRING];
    logic [BYTE-1:0]  pat_buf [MAX_PATTERN];
    logic             str_we, pat_we;
    logic [IW-1:0]    str_wa;
    logic [PIW-1:0]   pat_wa;

    logic [OW-1:0]     last_off, base_step, emit_off;
    logic              no_cand, past_end, str_full, pat_full;
    logic [NUM_PE-1:0] raw_hit, scan_hit, hits_clr;
    logic [LW-1:0]     low;
    logic              found;

    logic            valid, match, last, busy;
    logic [IW-1:0]   match_index;

    assign last_off  = OW'(str_len) - OW'(pat_len);
    assign no_cand   = (pat_len == '0) || (OW'(pat_len) > OW'(str_len));
    assign base_step = base + OW'(NUM_PE);
    assign past_end  = (base_step > last_off);
    assign str_full  = (str_len == SLW'(MAX_STRING));
    assign pat_full  = (pat_len == PLW'(MAX_PATTERN));

    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        logic [OW-1:0] off;
        assign off = base + OW'(k);

        sme_cmp_pe #(
            .BYTE       (BYTE),
            .MAX_STRING (MAX_STRING),
            .MAX_PATTERN(MAX_PATTERN),
            .OFF_W      (OW)
        ) u_pe (
            .str_mem(str_buf),
            .pat_mem(pat_buf),
            .pat_len(pat_len),
            .offset (off),
            .hit    (raw_hit[k])
        );

        // Offsets past the last legal start are masked before registering.
        assign scan_hit[k] = raw_hit[k] && (off <= last_off) && !no_cand;
    end

    always_comb begin
        low   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (hits[k] && !found) begin
                low   = LW'(k);
                found = 1'b1;
            end
        end
    end

    assign hits_clr = hits & ~(NUM_PE'(1) << low);
    assign emit_off = base + OW'(low);

    always_comb begin
        state_nx    = state;
        str_len_nx  = str_len;
        pat_len_nx  = pat_len;
        base_nx     = base;
        hits_nx     = hits;
        cnt_nx      = cnt;
        str_we      = 1'b0;
        str_wa      = '0;
        pat_we      = 1'b0;
        pat_wa      = '0;
        valid       = 1'b0;
        match       = 1'b0;
        last        = 1'b0;
        match_index = '0;

        case (state)
            IDLE, LOAD_PAT: begin
                if (bus.isstring) begin
                    str_we     = 1'b1;
                    str_len_nx = SLW'(1);
                    state_nx   = LOAD_STR;
                end else if (bus.ispattern) begin
                    if (state == IDLE) begin
                        pat_we     = 1'b1;
                        pat_len_nx = PLW'(1);
                        state_nx   = LOAD_PAT;
                    end else if (!pat_full) begin
                        pat_we     = 1'b1;
                        pat_wa     = pat_len[PIW-1:0];
                        pat_len_nx = pat_len + PLW'(1);
                    end
                end else if (state == LOAD_PAT) begin
                    base_nx  = '0;
                    cnt_nx   = '0;
                    hits_nx  = '0;
                    state_nx = SCAN;
                end
            end
            LOAD_STR: begin
                if (bus.isstring) begin
                    if (!str_full) begin
                        str_we     = 1'b1;
                        str_wa     = str_len[IW-1:0];
                        str_len_nx = str_len + SLW'(1);
                    end
                end else if (bus.ispattern) begin
                    pat_we     = 1'b1;
                    pat_len_nx = PLW'(1);
                    state_nx   = LOAD_PAT;
                end
            end
            SCAN: begin
                if (no_cand) begin
                    state_nx = FINAL;
                end else if (scan_hit != '0) begin
                    hits_nx  = scan_hit;
                    state_nx = EMIT;
                end else if (past_end) begin
                    state_nx = FINAL;
                end else begin
                    base_nx = base_step;
                end
            end
            EMIT: begin
                valid       = 1'b1;
                match       = 1'b1;
                match_index = emit_off[IW-1:0];
                if (bus.ready) begin
                    hits_nx = hits_clr;
                    cnt_nx  = cnt + SLW'(1);
                    if (hits_clr == '0) begin
                        if (past_end) begin
                            state_nx = FINAL;
                        end else begin
                            base_nx  = base_step;
                            state_nx = SCAN;
                        end
                    end
                end
            end
            FINAL: begin
                valid = 1'b1;
                last  = 1'b1;
                if (bus.ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            str_len <= '0;
            pat_len <= '0;
            base    <= '0;
            hits    <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            str_len <= str_len_nx;
            pat_len <= pat_len_nx;
            base    <= base_nx;
            hits    <= hits_nx;
            cnt     <= cnt_nx;
        end
    end

    // Buffer contents survive reset; only the lengths say what is valid.
    always_ff @(posedge clk) begin
        if (str_we) str_buf[str_wa] <= bus.chardata;
        if (pat_we) pat_buf[pat_wa] <= bus.chardata;
    end

    assign busy = (state == SCAN) || (state == EMIT) || (state == FINAL);

    assign bus.valid       = valid;
    assign bus.match       = match;
    assign bus.last        = last;
    assign bus.match_index = match_index;
    assign bus.busy        = busy;
    assign bus.match_count = cnt;
    assign dbg_state       = state;

endmodule

// File: tb/tb_sme_multi_match.sv
// Directed bench for sme_multi_match: table of load scenarios plus hand sequences.
module tb_sme_multi_match;
    import sme_pkg::*;

    localparam int NUM_PE      = 4;
    localparam int MAX_STRING  = 32;
    localparam int MAX_PATTERN = 8;
    localparam int BYTE        = 8;
    localparam int IW          = idx_w(MAX_STRING);

    typedef struct {
        string str;
        string pat;
        bit    pat_only;
        bit    rand_ready;
        int    n_exp;
        int    exp_idx[8];
    } vec_t;

    logic       clk;
    logic       reset;
    sme_state_e dbg_state;

    sme_multi_match_if #(.BYTE(BYTE), .MAX_STRING(MAX_STRING)) bus ();

    sme_multi_match #(
        .NUM_PE     (NUM_PE),
        .MAX_STRING (MAX_STRING),
        .MAX_PATTERN(MAX_PATTERN),
        .BYTE       (BYTE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [IW-1:0] exp_q[$];
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic load(input string s, input bit is_str);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            bus.chardata  = s[i];
            bus.isstring  = is_str;
            bus.ispattern = !is_str;
        end
    endtask

    task automatic end_load();
        @(negedge clk);
        bus.isstring  = 1'b0;
        bus.ispattern = 1'b0;
    endtask

    // scoreboard: consume beats until the terminator, checking against exp_q
    task automatic run_search(input bit rand_ready, input int exp_cnt, input string tag);
        bit            done;
        bit            stalled;
        int            cyc;
        logic          r;
        logic          s_match, s_last;
        logic [IW-1:0] s_idx;
        done    = 1'b0;
        stalled = 1'b0;
        cyc     = 0;
        s_match = 1'b0;
        s_last  = 1'b0;
        s_idx   = '0;
        while (!done && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (stalled)
                check({tag, "_hold"}, {bus.valid, bus.match, bus.last, bus.match_index},
                      {1'b1, s_match, s_last, s_idx});
            r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ready = r;
            stalled = 1'b0;
            if (bus.valid) begin
                if (!r) begin
                    stalled = 1'b1;
                    s_match = bus.match;
                    s_last  = bus.last;
                    s_idx   = bus.match_index;
                end else if (bus.match) begin
                    check({tag, "_match_last"}, bus.last, 0);
                    check({tag, "_expected_more"}, exp_q.size() > 0, 1);
                    if (exp_q.size() > 0)
                        check({tag, "_index"}, bus.match_index, exp_q.pop_front());
                end else begin
                    check({tag, "_term_last"}, bus.last, 1);
                    check({tag, "_term_index"}, bus.match_index, 0);
                    check({tag, "_missing_matches"}, exp_q.size(), 0);
                    done = 1'b1;
                end
            end
        end
        check({tag, "_timeout"}, done, 1);
        exp_q.delete();
        @(negedge clk);
        check({tag, "_idle_after"}, {bus.busy, bus.valid}, 0);
        check({tag, "_count"}, bus.match_count, exp_cnt);
        bus.ready = 1'b1;
    endtask

    initial begin
        string sat_str;
        bit    saw_valid;
        bit    reached;

        tbl[0] = '{str: "abcabcab", pat: "abc", pat_only: 0, rand_ready: 0, n_exp: 2,
                   exp_idx: '{0, 3, 0, 0, 0, 0, 0, 0}};
        tbl[1] = '{str: "", pat: "ca", pat_only: 1, rand_ready: 0, n_exp: 2,
                   exp_idx: '{2, 5, 0, 0, 0, 0, 0, 0}};
        tbl[2] = '{str: "aaaaaaaaa", pat: "aa", pat_only: 0, rand_ready: 0, n_exp: 8,
                   exp_idx: '{0, 1, 2, 3, 4, 5, 6, 7}};
        tbl[3] = '{str: "abab", pat: "ab", pat_only: 0, rand_ready: 1, n_exp: 2,
                   exp_idx: '{0, 2, 0, 0, 0, 0, 0, 0}};
`ifdef SME_WILDCARD_EN
        tbl[4] = '{str: "abcaxc", pat: "a.c", pat_only: 0, rand_ready: 0, n_exp: 2,
                   exp_idx: '{0, 3, 0, 0, 0, 0, 0, 0}};
`else
        tbl[4] = '{str: "abcaxc", pat: "a.c", pat_only: 0, rand_ready: 0, n_exp: 0,
                   exp_idx: '{0, 0, 0, 0, 0, 0, 0, 0}};
`endif
        // 35 bytes offered, only the first 32 ("x"*31 + "a") are kept
        sat_str = "";
        for (int i = 0; i < 31; i++) sat_str = {sat_str, "x"};
        sat_str = {sat_str, "abab"};
        tbl[5] = '{str: sat_str, pat: "xa", pat_only: 0, rand_ready: 0, n_exp: 1,
                   exp_idx: '{30, 0, 0, 0, 0, 0, 0, 0}};
        // 9 pattern bytes offered, 8 kept: last start offset is 10-8 = 2
        tbl[6] = '{str: "aaaaaaaaaa", pat: "aaaaaaaaa", pat_only: 0, rand_ready: 0, n_exp: 3,
                   exp_idx: '{0, 1, 2, 0, 0, 0, 0, 0}};

        reset         = 1'b0;
        bus.chardata  = '0;
        bus.isstring  = 1'b0;
        bus.ispattern = 1'b0;
        bus.ready     = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_beat", {bus.valid, bus.match, bus.last, bus.match_index}, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_count", bus.match_count, 0);
        check("reset_state", dbg_state, IDLE);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (!tbl[i].pat_only) load(tbl[i].str, 1'b1);
            load(tbl[i].pat, 1'b0);
            end_load();
            for (int j = 0; j < tbl[i].n_exp; j++) exp_q.push_back(IW'(tbl[i].exp_idx[j]));
            run_search(tbl[i].rand_ready, tbl[i].n_exp, $sformatf("vec%0d", i));
        end

        // pattern longer than string: terminator exactly two cycles after loading
        load("abc", 1'b1);
        load("abcd", 1'b0);
        bus.ready = 1'b0;
        end_load();
        @(negedge clk);
        check("long_pat_scan", {bus.busy, bus.valid}, 2'b10);
        @(negedge clk);
        check("long_pat_final", {bus.valid, bus.last, bus.match}, 3'b110);
        run_search(1'b0, 0, "long_pat");

        // reset mid-search: the search is dropped, no terminator follows
        load("aaaa", 1'b1);
        load("a", 1'b0);
        end_load();
        bus.ready = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            @(negedge clk);
            if (bus.match_count == 2) begin
                reached   = 1'b1;
                bus.ready = 1'b0;
            end
        end
        check("abort_reach_count2", reached, 1);
        check("abort_stalled_index", bus.match_index, 2);
        #2 reset = 1'b0;
        #1;
        check("abort_async_beat", {bus.valid, bus.match, bus.last, bus.busy}, 0);
        check("abort_async_count", bus.match_count, 0);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        bus.ready = 1'b1;
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_valid |= bus.valid;
        end
        check("abort_no_terminator", saw_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
